// File: rtl/midi_channel_decoder.sv
// MIDI byte-stream parser: running status, SysEx skip, real-time bypass,
// channel filtering and registered note / CC / pitch-bend pulses.

package MIDI;
    localparam logic STATUS_OFF = 1'b0;
    localparam logic STATUS_ON  = 1'b1;

    typedef struct packed {
        logic       status;
        logic [6:0] note_number;
        logic [6:0] velocity;
    } note_change_t;

    typedef struct packed {
        logic [6:0] controller_number;
        logic [6:0] value;
    } control_change_t;
endpackage

module midi_channel_decoder #(
    parameter logic [15:0] CHANNEL_MASK = 16'hFFFF,
    parameter bit          VEL0_IS_OFF  = 1'b1,
    parameter bit          BEND_EN      = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  byte_valid,
    input  logic [7:0]            rx_byte,
    output logic                  note_valid,
    output MIDI::note_change_t    note,
    output logic                  cc_valid,
    output MIDI::control_change_t cc,
    output logic                  bend_valid,
    output logic [13:0]           bend,
    output logic [3:0]            channel,
    output logic [7:0]            abort_count
);

    typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SYSEX} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] msg_type;
    logic [3:0] msg_ch;
    logic [6:0] d1;

    logic is_status;
    logic is_rt;
    logic is_chan;
    logic is_data;
    logic one_byte;
    logic done;
    logic abort;

    logic                  emit_note;
    logic                  emit_cc;
    logic                  emit_bend;
    MIDI::note_change_t    note_nxt;
    MIDI::control_change_t cc_nxt;
    logic [13:0]           bend_nxt;

    always_comb begin
        is_status = byte_valid & rx_byte[7];
        is_rt     = is_status & (rx_byte[7:3] == 5'b11111);
        is_chan   = is_status & (rx_byte[7:4] != 4'hF);
        is_data   = byte_valid & ~rx_byte[7];
        one_byte  = (msg_type == 4'hC) | (msg_type == 4'hD);
        done      = is_data & (((state == WAIT_D1) & one_byte) | (state == WAIT_D2));
        // Only WAIT_D2 holds a partially received message.
        abort     = is_status & ~is_rt & (state == WAIT_D2);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (is_status && !is_rt) begin
            if (is_chan)                state_nxt = WAIT_D1;
            else if (rx_byte == 8'hF0)  state_nxt = SYSEX;
            else                        state_nxt = IDLE;
        end else if (is_data) begin
            case (state)
                WAIT_D1: state_nxt = one_byte ? WAIT_D1 : WAIT_D2;
                WAIT_D2: state_nxt = WAIT_D1;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            msg_type    <= 4'h0;
            msg_ch      <= 4'h0;
            d1          <= 7'h00;
            abort_count <= 8'h00;
        end else begin
            if (is_chan) begin
                msg_type <= rx_byte[7:4];
                msg_ch   <= rx_byte[3:0];
            end else if (is_status && !is_rt) begin
                msg_type <= 4'h0;
                msg_ch   <= 4'h0;
            end
            if (is_data && state == WAIT_D1) d1 <= rx_byte[6:0];
            if (abort && abort_count != 8'hFF) abort_count <= abort_count + 8'd1;
        end
    end

    always_comb begin
        emit_note = done & ((msg_type == 4'h9) | (msg_type == 4'h8)) & CHANNEL_MASK[msg_ch];
        emit_cc   = done & (msg_type == 4'hB) & CHANNEL_MASK[msg_ch];
        emit_bend = BEND_EN & done & (msg_type == 4'hE) & CHANNEL_MASK[msg_ch];
        note_nxt.note_number = d1;
        note_nxt.velocity    = rx_byte[6:0];
        note_nxt.status      = MIDI::STATUS_OFF;
        if (msg_type == 4'h9 && !(VEL0_IS_OFF && rx_byte[6:0] == 7'h00))
            note_nxt.status = MIDI::STATUS_ON;
        cc_nxt.controller_number = d1;
        cc_nxt.value             = rx_byte[6:0];
        bend_nxt = {rx_byte[6:0], d1};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            note_valid <= 1'b0;
            note       <= '0;
            cc_valid   <= 1'b0;
            cc         <= '0;
            bend_valid <= 1'b0;
            bend       <= 14'h0000;
            channel    <= 4'h0;
        end else begin
            note_valid <= emit_note;
            cc_valid   <= emit_cc;
            bend_valid <= emit_bend;
            if (emit_note) note <= note_nxt;
            if (emit_cc)   cc   <= cc_nxt;
            if (emit_bend) bend <= bend_nxt;
            if (emit_note || emit_cc || emit_bend) channel <= msg_ch;
        end
    end

endmodule

// File: tb/tb_midi_channel_decoder.sv
// Scoreboard bench for midi_channel_decoder: a default instance and one
// restricted to channel 0 share the same byte stream.

module tb_midi_channel_decoder;

    typedef struct {
        int          kind;
        logic [14:0] data;
        logic [3:0]  ch;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        byte_valid = 1'b0;
    logic [7:0]  rx_byte = 8'h00;

    logic        note_valid, cc_valid, bend_valid;
    logic [14:0] note;
    logic [13:0] cc, bend;
    logic [3:0]  channel;
    logic [7:0]  abort_count;

    logic        note_valid_m, cc_valid_m, bend_valid_m;
    logic [14:0] note_m;
    logic [13:0] cc_m, bend_m;
    logic [3:0]  channel_m;
    logic [7:0]  abort_count_m;

    exp_t q0[$];
    exp_t q1[$];
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    int   exp_abort = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    midi_channel_decoder dut (
        .clk(clk), .reset(reset), .byte_valid(byte_valid), .rx_byte(rx_byte),
        .note_valid(note_valid), .note(note), .cc_valid(cc_valid), .cc(cc),
        .bend_valid(bend_valid), .bend(bend), .channel(channel),
        .abort_count(abort_count)
    );

    midi_channel_decoder #(.CHANNEL_MASK(16'h0001)) dut_m (
        .clk(clk), .reset(reset), .byte_valid(byte_valid), .rx_byte(rx_byte),
        .note_valid(note_valid_m), .note(note_m), .cc_valid(cc_valid_m), .cc(cc_m),
        .bend_valid(bend_valid_m), .bend(bend_m), .channel(channel_m),
        .abort_count(abort_count_m)
    );

    always @(negedge clk) begin
        int n;
        int k;
        logic [14:0] d;
        exp_t e;
        n = int'(note_valid) + int'(cc_valid) + int'(bend_valid);
        if (!reset && n != 0) begin
            compared++;
            k = note_valid ? 0 : (cc_valid ? 1 : 2);
            d = note_valid ? note : (cc_valid ? {1'b0, cc} : {1'b0, bend});
            if (n > 1) begin
                mismatched++;
                $display("FAIL multi_pulse: %0d pulses at cycle %0d, required 1", n, cyc);
            end else if (q0.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_pulse: kind %0d data %h ch %0d, required none", k, d, channel);
            end else begin
                e = q0.pop_front();
                if (k !== e.kind || d !== e.data || channel !== e.ch || cyc !== e.due) begin
                    mismatched++;
                    $display("FAIL pulse: kind %0d data %h ch %0d cyc %0d, required kind %0d data %h ch %0d cyc %0d",
                             k, d, channel, cyc, e.kind, e.data, e.ch, e.due);
                end
            end
        end
    end

    always @(negedge clk) begin
        int n;
        int k;
        logic [14:0] d;
        exp_t e;
        n = int'(note_valid_m) + int'(cc_valid_m) + int'(bend_valid_m);
        if (!reset && n != 0) begin
            compared++;
            k = note_valid_m ? 0 : (cc_valid_m ? 1 : 2);
            d = note_valid_m ? note_m : (cc_valid_m ? {1'b0, cc_m} : {1'b0, bend_m});
            if (n > 1) begin
                mismatched++;
                $display("FAIL multi_pulse_m: %0d pulses at cycle %0d, required 1", n, cyc);
            end else if (q1.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_pulse_m: kind %0d data %h ch %0d, required none", k, d, channel_m);
            end else begin
                e = q1.pop_front();
                if (k !== e.kind || d !== e.data || channel_m !== e.ch || cyc !== e.due) begin
                    mismatched++;
                    $display("FAIL pulse_m: kind %0d data %h ch %0d cyc %0d, required kind %0d data %h ch %0d cyc %0d",
                             k, d, channel_m, cyc, e.kind, e.data, e.ch, e.due);
                end
            end
        end
    end

    task automatic drive(input logic [7:0] b);
        @(posedge clk);
        #1;
        byte_valid = 1'b1;
        rx_byte = b;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        drive(b);
        idle();
    endtask

    // Call right after drive() of the completing byte.
    task automatic push(input int kind, input logic [14:0] data, input logic [3:0] ch);
        exp_t e;
        e.kind = kind;
        e.data = data;
        e.ch = ch;
        e.due = cyc + 1;
        q0.push_back(e);
        if (ch == 4'd0) q1.push_back(e);
    endtask

    task automatic drain(input string name);
        idle();
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (q0.size() !== 0) begin
            mismatched++;
            $display("FAIL %s_drain: %0d pulses missing, required 0", name, q0.size());
            q0.delete();
        end
        compared++;
        if (q1.size() !== 0) begin
            mismatched++;
            $display("FAIL %s_drain_m: %0d pulses missing, required 0", name, q1.size());
            q1.delete();
        end
    endtask

    task automatic check_abort(input string name);
        compared++;
        if (abort_count !== 8'(exp_abort) || abort_count_m !== 8'(exp_abort)) begin
            mismatched++;
            $display("FAIL %s_abort: got %0d/%0d, required %0d", name, abort_count, abort_count_m, exp_abort);
        end
    endtask

    task automatic check_zero(input string name);
        compared++;
        if ({note_valid, note, cc_valid, cc, bend_valid, bend, channel, abort_count} !== '0) begin
            mismatched++;
            $display("FAIL %s_outputs: nv %b note %h cv %b cc %h bv %b bend %h ch %h ab %h, required all 0",
                     name, note_valid, note, cc_valid, cc, bend_valid, bend, channel, abort_count);
        end
        compared++;
        if ({note_valid_m, note_m, cc_valid_m, cc_m, bend_valid_m, bend_m, channel_m, abort_count_m} !== '0) begin
            mismatched++;
            $display("FAIL %s_outputs_m: not all 0, required all 0", name);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        byte_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_abort = 0;
    endtask

    task automatic test_reset();
        do_reset();
        check_zero("reset");
    endtask

    task automatic test_note_on();
        send(8'h90);
        send(8'h3C);
        drive(8'h64);
        push(0, {1'b1, 7'h3C, 7'h64}, 4'd0);
        drain("note_on");
    endtask

    task automatic test_running_status();
        send(8'h91);
        send(8'h40);
        drive(8'h50);
        push(0, {1'b1, 7'h40, 7'h50}, 4'd1);
        idle();
        send(8'h40);
        drive(8'h00);
        push(0, {1'b0, 7'h40, 7'h00}, 4'd1);
        idle();
        send(8'h83);
        send(8'h10);
        drive(8'h20);
        push(0, {1'b0, 7'h10, 7'h20}, 4'd3);
        drain("running");
        compared++;
        if (note !== {1'b0, 7'h10, 7'h20} || channel !== 4'd3) begin
            mismatched++;
            $display("FAIL note_hold: note %h ch %0d, required %h ch 3", note, channel, {1'b0, 7'h10, 7'h20});
        end
    endtask

    task automatic test_realtime();
        send(8'hF8);
        send(8'hB0);
        send(8'hF8);
        send(8'h18);
        send(8'hFE);
        drive(8'h7F);
        push(1, {1'b0, 7'h18, 7'h7F}, 4'd0);
        idle();
        send(8'hF8);
        send(8'hB1);
        send(8'h7F);
        drive(8'h00);
        push(1, {1'b0, 7'h7F, 7'h00}, 4'd1);
        drain("realtime");
        check_abort("realtime");
    endtask

    task automatic test_abort_sysex();
        send(8'h90);
        send(8'h3C);
        send(8'hF0);
        send(8'h11);
        send(8'h22);
        send(8'hF7);
        send(8'h3C);
        send(8'h40);
        exp_abort++;
        drain("sysex");
        check_abort("sysex");
    endtask

    task automatic test_mask();
        send(8'h92);
        send(8'h3C);
        drive(8'h64);
        push(0, {1'b1, 7'h3C, 7'h64}, 4'd2);
        idle();
        send(8'hE0);
        send(8'h00);
        drive(8'h40);
        push(2, {1'b0, 14'h2000}, 4'd0);
        drain("mask");
    endtask

    task automatic test_dropped_types();
        send(8'hA0);
        send(8'h10);
        send(8'h20);
        send(8'hC5);
        send(8'h07);
        send(8'h08);
        send(8'hD0);
        send(8'h40);
        drain("dropped");
        check_abort("dropped");
    endtask

    task automatic test_back_to_back();
        drive(8'hE3);
        drive(8'h7F);
        drive(8'h7F);
        push(2, {1'b0, 14'h3FFF}, 4'd3);
        drive(8'h00);
        drive(8'h00);
        push(2, {1'b0, 14'h0000}, 4'd3);
        drive(8'hB0);
        drive(8'h01);
        drive(8'h02);
        push(1, {1'b0, 7'h01, 7'h02}, 4'd0);
        drive(8'h03);
        drive(8'h04);
        push(1, {1'b0, 7'h03, 7'h04}, 4'd0);
        drain("b2b");
    endtask

    task automatic test_reset_mid();
        send(8'h90);
        do_reset();
        send(8'h3C);
        send(8'h64);
        drain("reset_mid");
        check_zero("reset_mid");
    endtask

    task automatic test_abort_saturate();
        drive(8'h90);
        for (int i = 0; i < 260; i++) begin
            drive(8'h3C);
            drive(8'h90);
        end
        exp_abort = 255;
        drain("saturate");
        check_abort("saturate");
    endtask

    initial begin
        test_reset();
        test_note_on();
        test_running_status();
        test_realtime();
        test_abort_sysex();
        test_mask();
        test_dropped_types();
        test_back_to_back();
        test_reset_mid();
        test_abort_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
